// File: rtl/pitch_tone_synth_if.sv
// Valid/ready data stream used for both the pitch input and the audio output.
interface pitch_tone_synth_if #(
   parameter int unsigned DW = 16
) ();
   logic [DW-1:0] data;
   logic          valid;
   logic          ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pitch_tone_synth.sv
// Triangle-wave tone generator: plays FFT bin k at k*fs/NSamples, fs = clk/CLK_DIV.
// New pitches take effect only at phase wrap (or at once from silence), so tone changes are glitch-free.
module pitch_tone_synth #(
   parameter int unsigned NSamples = 1024,
   parameter int unsigned W        = 16,
   parameter int unsigned CLK_DIV  = 6
) (
   input  logic                clk,
   input  logic                reset,
   pitch_tone_synth_if.slave   pitch_input,
   pitch_tone_synth_if.master  audio_output
);
   localparam int unsigned P        = $clog2(NSamples);
   localparam int unsigned CW       = $clog2(CLK_DIV);
   localparam int unsigned SH       = W - P + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [P-1:0]  inc_q, inc_d;
   logic [P-1:0]  phase_q, phase_d;
   logic [P-1:0]  pend_k_q, pend_k_d;
   logic          pend_v_q, pend_v_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  data_q, data_d;
   logic          valid_q, valid_d;

   logic [P:0]    sum;
   logic [P-1:0]  u;
   logic [W-1:0]  tri_val;
   logic          sample_ev;
   logic          pitch_rdy;

   assign pitch_rdy          = !pend_v_q && !reset;
   assign pitch_input.ready  = pitch_rdy;
   assign audio_output.data  = data_q;
   assign audio_output.valid = valid_q;

   // Phase step with carry out marking a wrap; folded phase gives the rising/falling ramp.
   assign sum       = {1'b0, phase_q} + {1'b0, inc_q};
   assign u         = phase_q[P-1] ? (P'(NSamples - 1) - phase_q) : phase_q;
   assign tri_val   = (W'(u) << SH) - {1'b1, {(W-1){1'b0}}};
   assign sample_ev = (cnt_q == CNT_LAST) && (!valid_q || audio_output.ready);

   always_comb begin
      inc_d    = inc_q;
      phase_d  = phase_q;
      pend_k_d = pend_k_q;
      pend_v_d = pend_v_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = valid_q;

      // Slot counter parks at its last value while the output is stalled.
      if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + CW'(1);
      end else if (sample_ev) begin
         cnt_d = '0;
      end

      if (sample_ev) begin
         data_d  = (inc_q == '0) ? '0 : tri_val;
         valid_d = 1'b1;
         phase_d = sum[P-1:0];
         if (pend_v_q && sum[P]) begin
            inc_d    = pend_k_q;
            pend_v_d = 1'b0;
         end
      end else if (valid_q && audio_output.ready) begin
         valid_d = 1'b0;
      end

      // From silence there is no wrap to wait for: start the new tone at phase 0.
      if (pend_v_q && (inc_q == '0)) begin
         inc_d    = pend_k_q;
         phase_d  = '0;
         pend_v_d = 1'b0;
      end

      if (pitch_input.valid && pitch_rdy) begin
         pend_k_d = pitch_input.data;
         pend_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inc_q    <= '0;
         phase_q  <= '0;
         pend_k_q <= '0;
         pend_v_q <= 1'b0;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         inc_q    <= inc_d;
         phase_q  <= phase_d;
         pend_k_q <= pend_k_d;
         pend_v_q <= pend_v_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end
endmodule

// File: tb/tb_pitch_tone_synth.sv
// Directed bench for pitch_tone_synth: NSamples=1024, W=16, CLK_DIV=6.
module tb_pitch_tone_synth;
   localparam int unsigned NS = 1024;
   localparam int unsigned P  = 10;
   localparam int unsigned W  = 16;
   localparam int unsigned CD = 6;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pitch_tone_synth_if #(.DW(P)) pit ();
   pitch_tone_synth_if #(.DW(W)) aud ();

   pitch_tone_synth #(.NSamples(NS), .W(W), .CLK_DIV(CD)) dut (
      .clk          (clk),
      .reset        (reset),
      .pitch_input  (pit.slave),
      .audio_output (aud.master)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until the next held output sample; gives up after 40 cycles.
   task automatic get_sample(output int s, output int waited, output bit ok);
      ok = 1'b0;
      waited = 0;
      s = 0;
      while (!ok && waited < 40) begin
         tick();
         waited++;
         if (aud.valid === 1'b1) begin
            ok = 1'b1;
            s  = int'($signed(aud.data));
         end
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      pit.valid = 1'b0;
      pit.data = '0;
      aud.ready = 1'b1;
      repeat (3) tick();
      vectors++;
      if (pit.ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pitch_ready: got %b expected 0", pit.ready);
      end
      vectors++;
      if (aud.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_audio_valid: got %b expected 0", aud.valid);
      end
      vectors++;
      if (aud.data !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_audio_data: got %h expected 0000", aud.data);
      end
      reset = 1'b0;
      tick();
      vectors++;
      if (pit.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_ready: got %b expected 1", pit.ready);
      end
      n = 1;
      while (aud.valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (n != 6 || aud.data !== 16'h0000) begin
         miscompares++;
         $display("FAIL first_sample: got cycles=%0d data=%h expected cycles=6 data=0000", n, aud.data);
      end
   endtask

   task automatic test_silence();
      int s, w;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != 0 || w != 6) begin
            miscompares++;
            $display("FAIL silence[%0d]: got ok=%0b data=%0d gap=%0d expected data=0 gap=6", i, ok, s, w);
         end
      end
   endtask

   task automatic test_pitch_idle();
      int s, w;
      bit ok;
      int e[8] = '{-32768, 0, 32640, -128, -32768, 0, 32640, -128};
      pit.valid = 1'b1;
      pit.data = 10'd256;
      tick();
      pit.valid = 1'b0;
      vectors++;
      if (pit.ready !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_pending_ready: got %b expected 0", pit.ready);
      end
      tick();
      vectors++;
      if (pit.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_applied_ready: got %b expected 1", pit.ready);
      end
      for (int i = 0; i < 8; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e[i]) begin
            miscompares++;
            $display("FAIL k256[%0d]: got ok=%0b data=%0d expected %0d", i, ok, s, e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s, w;
      bit ok;
      int e1[4] = '{-32768, 0, 32640, -128};
      logic r1[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int e2[9] = '{-32768, 0, 32640, -128, -32768, -16384, 0, 16384, 32640};
      pit.valid = 1'b1;
      pit.data = 10'd256;
      tick();
      pit.data = 10'd128;
      for (int i = 0; i < 4; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e1[i] || pit.ready !== r1[i]) begin
            miscompares++;
            $display("FAIL b2b_wait[%0d]: got ok=%0b data=%0d ready=%b expected data=%0d ready=%b",
                     i, ok, s, pit.ready, e1[i], r1[i]);
         end
      end
      tick();
      pit.valid = 1'b0;
      vectors++;
      if (pit.ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_accept128_ready: got %b expected 0", pit.ready);
      end
      for (int i = 0; i < 9; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e2[i]) begin
            miscompares++;
            $display("FAIL b2b_seq[%0d]: got ok=%0b data=%0d expected %0d", i, ok, s, e2[i]);
         end
      end
   endtask

   task automatic test_stall();
      int s, w;
      bit ok;
      int e[4] = '{16256, -128, -16512, -32768};
      aud.ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         vectors++;
         if (aud.valid !== 1'b1 || aud.data !== 16'h7F80) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got valid=%b data=%h expected valid=1 data=7f80",
                     i, aud.valid, aud.data);
         end
      end
      aud.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e[i] || (i == 0 && w != 1)) begin
            miscompares++;
            $display("FAIL stall_resume[%0d]: got ok=%0b data=%0d wait=%0d expected %0d",
                     i, ok, s, w, e[i]);
         end
      end
   endtask

   task automatic test_silence_switch();
      int s, w;
      bit ok;
      int e[9] = '{-16384, 0, 16384, 32640, 16256, -128, -16512, 0, 0};
      logic r[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int e2[4] = '{-32768, 0, 32640, -128};
      pit.valid = 1'b1;
      pit.data = 10'd0;
      tick();
      pit.valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e[i] || pit.ready !== r[i]) begin
            miscompares++;
            $display("FAIL to_silence[%0d]: got ok=%0b data=%0d ready=%b expected data=%0d ready=%b",
                     i, ok, s, pit.ready, e[i], r[i]);
         end
      end
      pit.valid = 1'b1;
      pit.data = 10'd256;
      tick();
      pit.valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != e2[i]) begin
            miscompares++;
            $display("FAIL from_silence[%0d]: got ok=%0b data=%0d expected %0d", i, ok, s, e2[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s, w;
      bit ok;
      aud.ready = 1'b0;
      pit.valid = 1'b1;
      pit.data = 10'd128;
      tick();
      pit.valid = 1'b0;
      vectors++;
      if (aud.valid !== 1'b1 || pit.ready !== 1'b0) begin
         miscompares++;
         $display("FAIL pre_reset_state: got valid=%b ready=%b expected valid=1 ready=0",
                  aud.valid, pit.ready);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if (aud.valid !== 1'b0 || pit.ready !== 1'b0 || aud.data !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_reset: got valid=%b ready=%b data=%h expected valid=0 ready=0 data=0000",
                  aud.valid, pit.ready, aud.data);
      end
      reset = 1'b0;
      aud.ready = 1'b1;
      tick();
      vectors++;
      if (pit.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_release_ready: got %b expected 1", pit.ready);
      end
      for (int i = 0; i < 4; i++) begin
         get_sample(s, w, ok);
         vectors++;
         if (!ok || s != 0) begin
            miscompares++;
            $display("FAIL mid_reset_silence[%0d]: got ok=%0b data=%0d expected 0", i, ok, s);
         end
      end
   endtask

   initial begin
      test_reset();
      test_silence();
      test_pitch_idle();
      test_back_to_back();
      test_stall();
      test_silence_switch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pitch_tone_synth.md
# pitch_tone_synth

Tone generator at the far end of the pitch-detector output stream. It accepts an FFT bin index on a valid/ready `dstream` and produces a signed triangle-wave audio stream at that bin's frequency (k·fs/NSamples). The output is paced at fs = clk/CLK_DIV. Pitch changes take effect only at phase wrap, so they are glitch-free. It closes the loop for audible checks of `fft_pitch_detect` and drives the audio output path.

## Interface
- `NSamples`, 1024: FFT length. Power of 2. Sets P = $clog2(NSamples), the phase and pitch width.
- `W`, 16: audio sample width, signed. W ≥ P required.
- `CLK_DIV`, 6: clock cycles per output sample slot. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `pitch_input.data`  in  P  bin index k. k = 0 means silence.
- `pitch_input.valid`  in  1  pitch offered.
- `pitch_input.ready`  out  1  high when no pitch is pending.
- `audio_output.data`  out  W  signed sample.
- `audio_output.valid`  out  1  sample held.
- `audio_output.ready`  in  1  sink accepts.

## Operation
- Registers:
  - `inc` (P bits): active pitch.
  - `phase` (P bits): wraps mod NSamples.
  - `pend_k` (P bits) and `pend_v` (1 bit): pending pitch.
  - `cnt`: slot counter, 0..CLK_DIV-1.
- Pitch handshake:
  - `pitch_input.ready = !pend_v && !reset`.
  - On `valid && ready`: `pend_k <= data`, `pend_v <= 1`.
- Pending pitch is applied on one of two events:
  - (a) Immediately on the next cycle if `inc == 0`: `inc <= pend_k`, `phase <= 0`, `pend_v <= 0`.
  - (b) On a sample event whose phase update carries (phase + inc ≥ NSamples): `inc <= pend_k`, `pend_v <= 0`, `phase <= (phase + inc) mod NSamples`. The old inc is used for this step.
- Slot counter:
  - `cnt` increments each cycle until it reaches CLK_DIV-1.
  - It holds at CLK_DIV-1 while `audio_output.valid && !audio_output.ready` (stall).
- Sample event: `cnt == CLK_DIV-1` and the output slot is free (`!valid || ready`). On a sample event:
  - `audio_output.data <= tri(phase)`.
  - `valid <= 1`.
  - `phase <= phase + inc` (mod NSamples).
  - `cnt <= 0`.
- Output valid:
  - If `valid && ready` without a sample event, `valid <= 0`.
  - Data holds while valid is high and ready is low.
- Waveform: u = phase[P-1] ? (NSamples-1-phase) : phase, giving 0..NSamples/2-1.
  - tri = (u << (W-P+1)) − 2^(W-1), computed in W+1 bits and truncated to W bits signed.
  - When `inc == 0`, the sample is forced to 0 and phase stays 0.
- Stalls: while stalled the phase does not advance. Every generated sample is delivered; none are dropped.
- Simultaneous events:
  - A pitch accept and an apply in the same cycle cannot occur, because ready is low while pend_v is set.
  - A sample event and case (a) in the same cycle: the sample uses inc = 0, so it outputs 0. The new inc is used from the next slot.

## Timing
- During and after reset, all outputs and registers are 0: `pitch_input.ready = 0`, `audio_output.valid = 0`, `audio_output.data = 0`.
- The first cycle after reset deasserts has `pitch_input.ready = 1`.
- The first sample event occurs CLK_DIV cycles after reset deasserts. That sample is 0 if no pitch has been applied.
- Pitch latency from idle:
  - Accept at edge n, so `pend_v = 1` after edge n.
  - Applied at edge n+1, so `inc = k` and ready is high again after n+1.
  - The first sample reflecting k (value −2^(W-1)) is produced at the next sample event.
- Pitch latency while running: the pitch is applied at the first carry sample event after the accept. That is at most ceil(NSamples/inc) slots.
- Output cadence: with `audio_output.ready` tied high, valid pulses for one cycle every CLK_DIV cycles.
- Reset mid-operation clears pending, phase, inc and valid on the next edge. A held sample is discarded.

## Test plan
- Reset, then no pitch, with `audio_output.ready = 1` → a valid pulse every 6 cycles, data = 0. `pitch_input.ready` is 0 during reset and 1 afterwards.
- Apply pitch k = 256 from idle (NSamples = 1024, W = 16) → samples −32768, 0, 32640, −128, repeating with period 4.
- Apply k = 256 while running, then offer k = 128 immediately → ready stays low until the carry sample. The new period of 8 begins continuing from phase 0: −32768, −16384, 0, …
- Stall with `audio_output.ready = 0` for 20 cycles during k = 256 → valid and data are held. After release, the sequence resumes with no skipped sample.
- Apply k = 0 while running k = 256 → silence (0) starts right after the next wrap. The phase is 0 when a later pitch is applied.
- Assert reset while a pitch is pending and a sample is stalled → next cycle: valid = 0, ready = 0. After release, the block produces silent samples until a new pitch is given.
